// File: rtl/parallel_pkg.sv
// Shared constants and output-state encoding for the parallel receiver.
package parallel_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    OVER  = 2'b10
  } out_state_e;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/parallel_bitcnt.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and a wrap pulse
// that marks the edge accepting the last bit of a word.
module parallel_bitcnt
  import parallel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Clear wins over enable, so a bit strobed alongside a resync never completes a word.
  assign wrap = en && !clr && (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/parallel_rx.sv
// Serial-to-parallel receiver: shifts SI on Sh strobes, publishes each full
// word on Q with a valid/overrun handshake against the consumer's Ack.
module parallel_rx
  import parallel_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Sh,
  input  logic             SI,
  input  logic             Clr,
  input  logic             Ack,
  output logic [WIDTH-1:0] Q,
  output logic             V,
  output logic             Ovr,
  output logic             Busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] s_next;
  logic [CW-1:0]    count;
  logic             done;
  out_state_e       state;
  out_state_e       state_next;

  parallel_bitcnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bitcnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (Clr),
    .en    (Sh),
    .count (count),
    .wrap  (done)
  );

  // The completed word is taken from s_next so the final bit lands in Q on its own edge.
  always_comb begin
    if (LSB_FIRST) s_next = {SI, s_reg[WIDTH-1:1]};
    else           s_next = {s_reg[WIDTH-2:0], SI};
  end

  always_ff @(posedge clk) begin
    if (rst || Clr) begin
      s_reg <= '0;
    end else if (Sh) begin
      s_reg <= s_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= '0;
    end else if (done) begin
      Q <= s_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (done) state_next = FULL;
      FULL: begin
        if (done && Ack)  state_next = FULL;
        else if (done)    state_next = OVER;
        else if (Ack)     state_next = EMPTY;
      end
      OVER: begin
        if (done && Ack)  state_next = FULL;
        else if (Ack)     state_next = EMPTY;
      end
      default:            state_next = EMPTY;
    endcase
  end

  // Ovr is sticky across Ack; only reset or a framing resync clears it.
  always_ff @(posedge clk) begin
    if (rst || Clr) begin
      Ovr <= 1'b0;
    end else if (done && !Ack && (state != EMPTY)) begin
      Ovr <= 1'b1;
    end
  end

  assign V    = (state != EMPTY);
  assign Busy = (count != '0);

endmodule

// File: tb/tb_parallel_rx.sv
// Bench for parallel_rx: directed scenarios with literal expectations plus
// random traffic compared every cycle against a queue-based word model.
module tb_parallel_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sh  = 1'b0;
  logic         si  = 1'b0;
  logic         clr = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] q_lsb, q_msb;
  logic         v_lsb, v_msb, ovr_lsb, ovr_msb, busy_lsb, busy_msb;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Reference state: bits of the word in progress, in arrival order.
  bit           m_bits[$];
  logic [W-1:0] m_q_lsb = '0;
  logic [W-1:0] m_q_msb = '0;
  bit           m_v     = 1'b0;
  bit           m_ovr   = 1'b0;

  parallel_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .Sh(sh), .SI(si), .Clr(clr), .Ack(ack),
    .Q(q_lsb), .V(v_lsb), .Ovr(ovr_lsb), .Busy(busy_lsb)
  );

  parallel_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .Sh(sh), .SI(si), .Clr(clr), .Ack(ack),
    .Q(q_msb), .V(v_msb), .Ovr(ovr_msb), .Busy(busy_msb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Applies the spec rules to the inputs present at the edge just taken.
  task automatic model_edge();
    bit           done;
    logic [W-1:0] w_lsb, w_msb;
    done  = 1'b0;
    w_lsb = '0;
    w_msb = '0;
    if (rst) begin
      m_bits.delete();
      m_q_lsb = '0;
      m_q_msb = '0;
      m_v     = 1'b0;
      m_ovr   = 1'b0;
      return;
    end
    if (clr) begin
      m_bits.delete();
      m_ovr = 1'b0;
    end else if (sh) begin
      m_bits.push_back(si);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          w_lsb[i]       = m_bits[i];
          w_msb[W-1-i]   = m_bits[i];
        end
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (m_v && !ack) m_ovr = 1'b1;
      m_v     = 1'b1;
      m_q_lsb = w_lsb;
      m_q_msb = w_msb;
    end else if (ack) begin
      m_v = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic c, input logic a);
    rst = r; sh = s; si = d; clr = c; ack = a;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0; sh = 1'b0; si = 1'b0; clr = 1'b0; ack = 1'b0;
  endtask

  task automatic shift_word(input logic [W-1:0] bits_in_order, input int gap, input bit ack_last);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, bits_in_order[W-1-i], 1'b0, ack_last && (i == W-1));
      if (i != W-1) begin
        for (int g = 0; g < gap; g++) begin
          step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          check("busy_in_gap", busy_lsb, 1'b1);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("q_lsb",    q_lsb,    m_q_lsb);
      check("q_msb",    q_msb,    m_q_msb);
      check("v_lsb",    v_lsb,    m_v);
      check("v_msb",    v_msb,    m_v);
      check("ovr_lsb",  ovr_lsb,  m_ovr);
      check("ovr_msb",  ovr_msb,  m_ovr);
      check("busy_lsb", busy_lsb, m_bits.size() != 0);
      check("busy_msb", busy_msb, m_bits.size() != 0);
    end
  end

  initial begin
    bit r_rst, r_sh, r_si, r_clr, r_ack;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    check("rst_q",    q_lsb,    4'b0000);
    check("rst_v",    v_lsb,    1'b0);
    check("rst_ovr",  ovr_lsb,  1'b0);
    check("rst_busy", busy_lsb, 1'b0);

    // Back-to-back word, arrival order 1,0,1,1.
    shift_word(4'b1011, 0, 1'b0);
    check("w1_q",     q_lsb,    4'b1101);
    check("w1_v",     v_lsb,    1'b1);
    check("w1_ovr",   ovr_lsb,  1'b0);
    check("w1_busy",  busy_lsb, 1'b0);
    check("w1_q_msb", q_msb,    4'b1011);

    // Same word with two idle cycles between bits.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(4'b1011, 2, 1'b0);
    check("gap_q", q_lsb, 4'b1101);

    // Overwrite without Ack, then Ack, then Clr.
    shift_word(4'b1100, 0, 1'b0);
    check("ovw_q",   q_lsb,   4'b0011);
    check("ovw_v",   v_lsb,   1'b1);
    check("ovw_ovr", ovr_lsb, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ack_v",   v_lsb,   1'b0);
    check("ack_ovr", ovr_lsb, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ack_empty_v", v_lsb, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovr", ovr_lsb, 1'b0);

    // Ack coinciding with completion of the second word.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(4'b1011, 0, 1'b0);
    shift_word(4'b1100, 0, 1'b1);
    check("ackc_q",   q_lsb,   4'b0011);
    check("ackc_v",   v_lsb,   1'b1);
    check("ackc_ovr", ovr_lsb, 1'b0);

    // Clr with a simultaneous strobe discards the partial word and that bit.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_clr_busy", busy_lsb, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_busy", busy_lsb, 1'b0);
    check("clr_v",    v_lsb,    1'b0);
    shift_word(4'b0011, 0, 1'b0);
    check("clr_q",    q_lsb,    4'b1100);

    // Reset mid-word on the MSB-first receiver, then a fresh word.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mrst_q",    q_msb,    4'b0000);
    check("mrst_v",    v_msb,    1'b0);
    check("mrst_ovr",  ovr_msb,  1'b0);
    check("mrst_busy", busy_msb, 1'b0);
    shift_word(4'b1011, 0, 1'b0);
    check("msb_q", q_msb, 4'b1011);
    check("msb_v", v_msb, 1'b1);

    // Random traffic; Clr and Ack are kept apart.
    for (int n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_sh  = ($urandom_range(0, 9) < 6);
      r_si  = $urandom_range(0, 1);
      r_clr = ($urandom_range(0, 39) == 0);
      r_ack = !r_clr && ($urandom_range(0, 9) < 2);
      step(r_rst, r_sh, r_si, r_clr, r_ack);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parallel_rx.md
PARALLEL_RX -- requirements
Module: parallel_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: word length in bits, legal range 2..16.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = first received bit lands in Q[0]; 0 = first received bit lands in Q[WIDTH-1].
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Sh, input, 1 bit: shift strobe from the transmitting register; SI is a valid bit on this edge.
REQ-006 SHALL have port SI, input, 1 bit: serial data.
REQ-007 SHALL have port Clr, input, 1 bit: framing resync; discards any partial word.
REQ-008 SHALL have port Ack, input, 1 bit: consumer has taken Q.
REQ-009 SHALL have port Q, output, WIDTH bits: last completed word, registered.
REQ-010 SHALL have port V, output, 1 bit: Q holds an unacknowledged word.
REQ-011 SHALL have port Ovr, output, 1 bit: sticky flag, a word was overwritten before Ack.
REQ-012 SHALL have port Busy, output, 1 bit: partial word in progress (bit count != 0).

Function
REQ-013 Sh=1, Clr=0 SHALL shift SI into internal register S: LSB_FIRST=1 gives S <= {SI, S[WIDTH-1:1]}; LSB_FIRST=0 gives S <= {S[WIDTH-2:0], SI}.
REQ-014 Sh=0 SHALL hold S and the bit counter; idle gaps between bits of one word SHALL be legal.
REQ-015 Bit counter SHALL count 0..WIDTH-1, incrementing per accepted Sh, and SHALL wrap to 0 on the WIDTH-th bit.
REQ-016 On the edge accepting the WIDTH-th bit, Q SHALL load the complete word including that bit, and V SHALL be 1 from that edge; latency is 0 cycles after the last Sh edge.
REQ-017 Output state machine SHALL use EMPTY (V=0), FULL (V=1, Ovr=0) and OVER (V=1, Ovr=1).
REQ-018 EMPTY SHALL go to FULL on completion.
REQ-019 FULL SHALL go to EMPTY on Ack without completion, and SHALL go to OVER on completion without Ack.
REQ-020 OVER SHALL go to EMPTY on Ack without completion, with Ovr staying 1.
REQ-021 Completion and Ack in the same cycle SHALL load the new word into Q with V=1, and SHALL NOT set Ovr.
REQ-022 Ack while V=0 SHALL be ignored.
REQ-023 Completion while V=1 without Ack SHALL overwrite Q and SHALL set Ovr.
REQ-024 Ovr SHALL clear only on rst or Clr.
REQ-025 Clr SHALL zero S, the bit counter and Ovr, SHALL leave Q and V unchanged, and SHALL override Sh in the same cycle (that bit is discarded).
REQ-026 Busy SHALL be 1 exactly when the bit counter is non-zero.

Reset
REQ-027 rst SHALL have priority over all inputs; at the next edge Q=0, V=0, Ovr=0, Busy=0, S=0, counter=0, state=EMPTY.
REQ-028 rst mid-word SHALL discard the partial word; the first Sh after rst releases SHALL count as bit 0.

Structure
REQ-029 Shared package parallel_pkg SHALL hold the WIDTH default, the counter width constant $clog2(WIDTH), and the output-state encoding.
REQ-030 Sub-module parallel_bitcnt (modulo-WIDTH counter with clear, enable and wrap pulse) SHALL be instantiated once; all other logic SHALL be inline.

Verification
REQ-031 WIDTH=4, LSB_FIRST=1, rst then SI=1,0,1,1 on 4 consecutive Sh cycles -> Q=4'b1101, V=1, Ovr=0, Busy=0 after the 4th edge.
REQ-032 Same word with Sh=0 gaps of 2 cycles between bits -> identical Q=4'b1101; Busy=1 during the gaps.
REQ-033 Word 4'b1101 with no Ack, then bits 1,1,0,0 -> Q=4'b0011, V=1, Ovr=1; then Ack -> V=0, Ovr=1; then Clr -> Ovr=0.
REQ-034 Ack held high on the completion edge of the second word -> Q updates to the second word, V=1, Ovr=0.
REQ-035 Two bits shifted, then Clr with Sh=1 in the same cycle, then 4 bits 0,0,1,1 -> Busy=0 after Clr, Q=4'b1100.
REQ-036 LSB_FIRST=0, bits 1,0,1,1 -> Q=4'b1011; rst after 2 bits -> all outputs 0, next word framed from bit 0.
